e_mdu: RTL and testbench

E_MDU -- requirements
Module: e_mdu

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/e_mdu_if.sv | 14 +
 rtl/e_mdu.sv | 106 ++++++++++
 tb/tb_e_mdu.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU op encodings, cycle counts and op-legality helper.
// MDU_MADD_EN enables the madd/maddu accumulate ops (7, 8).
package mdu_pkg;
    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8
    } op_e;

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    function automatic logic op_valid(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: op_valid = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: op_valid = 1'b1;
`endif
            default: op_valid = 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/e_mdu_if.sv
// E-stage issue bus into the MDU plus its busy/HI/LO results.
interface e_mdu_if;
    logic        start;
    logic        flush;
    logic [3:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, flush, op, v1, v2, input busy, hi, lo);
    modport slave  (input start, flush, op, v1, v2, output busy, hi, lo);
endinterface

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO; result computed at issue, retired when busy falls.
// MDU_MADD_EN adds madd/maddu accumulate into {hi,lo}.
module e_mdu
    import mdu_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    e_mdu_if.slave mdu
);
    state_e      state;
    logic [3:0]  cnt;
    logic        busy_q;
    logic [31:0] hi_q, lo_q;
    logic [63:0] pend;
    logic        pend_wr;

    logic        accept, div_zero;
    logic [63:0] prod_s, prod_u, res;
    logic [31:0] abs_a, abs_b, mag_q, mag_r, uq, ur;

    assign accept   = mdu.start && !mdu.flush && (state == S_IDLE) && op_valid(mdu.op);
    assign div_zero = (mdu.v2 == 32'd0);

    // Signed divide goes through magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN.
    always_comb begin
        prod_s = {{32{mdu.v1[31]}}, mdu.v1} * {{32{mdu.v2[31]}}, mdu.v2};
        prod_u = {32'd0, mdu.v1} * {32'd0, mdu.v2};
        abs_a  = mdu.v1[31] ? -mdu.v1 : mdu.v1;
        abs_b  = mdu.v2[31] ? -mdu.v2 : mdu.v2;
        mag_q  = 32'd0;
        mag_r  = 32'd0;
        uq     = 32'd0;
        ur     = 32'd0;
        if (!div_zero) begin
            mag_q = abs_a / abs_b;
            mag_r = abs_a % abs_b;
            uq    = mdu.v1 / mdu.v2;
            ur    = mdu.v1 % mdu.v2;
        end
        res = 64'd0;
        case (mdu.op)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV:   res = {(mdu.v1[31] ? -mag_r : mag_r),
                             ((mdu.v1[31] ^ mdu.v2[31]) ? -mag_q : mag_q)};
            OP_DIVU:  res = {ur, uq};
`ifdef MDU_MADD_EN
            OP_MADD:  res = {hi_q, lo_q} + prod_s;
            OP_MADDU: res = {hi_q, lo_q} + prod_u;
`endif
            default:  res = 64'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend    <= 64'd0;
            pend_wr <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (mdu.op)
                            OP_MTHI: hi_q <= mdu.v1;
                            OP_MTLO: lo_q <= mdu.v1;
                            OP_DIV, OP_DIVU: begin
                                state   <= S_BUSY;
                                busy_q  <= 1'b1;
                                cnt     <= 4'(DIV_CYCLES - 1);
                                pend    <= res;
                                pend_wr <= !div_zero;
                            end
                            default: begin
                                state   <= S_BUSY;
                                busy_q  <= 1'b1;
                                cnt     <= 4'(MULT_CYCLES - 1);
                                pend    <= res;
                                pend_wr <= 1'b1;
                            end
                        endcase
                    end
                end
                S_BUSY: begin
                    // HI/LO only move here, on the edge where busy drops.
                    if (cnt == 4'd0) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        if (pend_wr) {hi_q, lo_q} <= pend;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mdu.busy = busy_q;
    assign mdu.hi   = hi_q;
    assign mdu.lo   = lo_q;
endmodule

// File: tb/tb_e_mdu.sv
// Directed table-driven bench for e_mdu plus hand sequences for flush, busy-start and reset.
// Expectations for ops 7/8 follow MDU_MADD_EN.
module tb_e_mdu;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    e_mdu_if bus ();
    e_mdu dut (.clk(clk), .reset(reset), .mdu(bus.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
        logic [31:0] h;
        logic [31:0] l;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic f);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.v1 = a; bus.v2 = b; bus.flush = f;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.flush = 1'b0; bus.op = 4'd0;
    endtask

    task automatic wait_idle(output int n, output logic stable);
        logic [31:0] h0, l0;
        n = 0;
        stable = 1'b1;
        @(negedge clk);
        h0 = bus.hi;
        l0 = bus.lo;
        while (bus.busy && n < 40) begin
            if (bus.hi !== h0 || bus.lo !== l0) stable = 1'b0;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n, c;
        logic st;

        bus.start = 1'b0; bus.flush = 1'b0; bus.op = 4'd0; bus.v1 = 32'd0; bus.v2 = 32'd0;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        reset = 1'b1;

        vecs.push_back('{OP_MULT,  32'hFFFFFFFF, 32'd2,        5,  32'hFFFFFFFF, 32'hFFFFFFFE});
        vecs.push_back('{OP_MULTU, 32'hFFFFFFFF, 32'd2,        5,  32'h00000001, 32'hFFFFFFFE});
        vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD});
        vecs.push_back('{OP_DIVU,  32'd7,        32'd2,        10, 32'd1,        32'd3});
        vecs.push_back('{OP_DIV,   32'd5,        32'd0,        10, 32'd1,        32'd3});
        vecs.push_back('{OP_DIVU,  32'd9,        32'd0,        10, 32'd1,        32'd3});
        vecs.push_back('{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'd0,        32'h80000000});
        vecs.push_back('{OP_MULT,  32'd7,        32'hFFFFFFFD, 5,  32'hFFFFFFFF, 32'hFFFFFFEB});
        vecs.push_back('{OP_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'd1,        32'hFFFFFFFD});
        vecs.push_back('{OP_MTHI,  32'h1234,     32'd0,        0,  32'h1234,     32'hFFFFFFFD});
        vecs.push_back('{OP_MTLO,  32'd1,        32'd0,        0,  32'h1234,     32'd1});
        vecs.push_back('{OP_NONE,  32'd5,        32'd5,        0,  32'h1234,     32'd1});
        vecs.push_back('{4'd9,     32'd5,        32'd5,        0,  32'h1234,     32'd1});
        vecs.push_back('{OP_MULTU, 32'h10000,    32'h10000,    5,  32'd1,        32'd0});
        vecs.push_back('{OP_MTHI,  32'd0,        32'd0,        0,  32'd0,        32'd0});
        vecs.push_back('{OP_MTLO,  32'd1,        32'd0,        0,  32'd0,        32'd1});
`ifdef MDU_MADD_EN
        vecs.push_back('{OP_MADD,  32'd2,        32'd3,        5,  32'd0,        32'd7});
        vecs.push_back('{OP_MADD,  32'hFFFFFFFF, 32'd1,        5,  32'd0,        32'd6});
        vecs.push_back('{OP_MADDU, 32'hFFFFFFFF, 32'd2,        5,  32'd2,        32'd4});
`else
        vecs.push_back('{OP_MADD,  32'd2,        32'd3,        0,  32'd0,        32'd1});
        vecs.push_back('{OP_MADD,  32'hFFFFFFFF, 32'd1,        0,  32'd0,        32'd1});
        vecs.push_back('{OP_MADDU, 32'hFFFFFFFF, 32'd2,        0,  32'd0,        32'd1});
`endif

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            wait_idle(n, st);
            check($sformatf("v%0d_busy_cycles", i), n, vecs[i].cyc);
            check($sformatf("v%0d_stable", i), {31'd0, st}, 32'd1);
            check($sformatf("v%0d_hi", i), bus.hi, vecs[i].h);
            check($sformatf("v%0d_lo", i), bus.lo, vecs[i].l);
        end

        // Flushed starts must leave everything untouched.
        issue(OP_MTHI, 32'hAAAA, 32'd0, 1'b0);
        issue(OP_MTLO, 32'hBBBB, 32'd0, 1'b0);
        issue(OP_MULT, 32'd3, 32'd3, 1'b1);
        @(negedge clk);
        check("flush_mult_busy", {31'd0, bus.busy}, 32'd0);
        issue(OP_MTHI, 32'h5555, 32'd0, 1'b1);
        @(negedge clk);
        check("flush_mthi_hi", bus.hi, 32'hAAAA);
        check("flush_lo", bus.lo, 32'hBBBB);

        // Start and flush arriving while busy are ignored; the div still retires.
        issue(OP_DIV, 32'd100, 32'd7, 1'b0);
        c = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.busy) c++;
        end
        issue(OP_MTHI, 32'hDEAD, 32'd0, 1'b0);
        issue(OP_MULT, 32'd1, 32'd1, 1'b1);
        wait_idle(n, st);
        check("busy_start_pre", c, 32'd3);
        check("busy_start_post", n, 32'd5);
        check("busy_start_hi", bus.hi, 32'd2);
        check("busy_start_lo", bus.lo, 32'd14);
        check("busy_start_stable", {31'd0, st}, 32'd1);

        // Async reset mid-divide discards the result, then a mult completes normally.
        issue(OP_DIV, 32'd50, 32'd3, 1'b0);
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_hi", bus.hi, 32'd0);
        check("mid_rst_lo", bus.lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        issue(OP_MULT, 32'd3, 32'd4, 1'b0);
        wait_idle(n, st);
        check("post_rst_cycles", n, 32'd5);
        check("post_rst_hi", bus.hi, 32'd0);
        check("post_rst_lo", bus.lo, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
